// File: rtl/game_pkg.sv
// Operation codes shared between the button front end and the cursor/select stage.
package game_pkg;

  localparam int OP_W    = 3;
  localparam int NUM_BTN = 6;

  typedef enum logic [OP_W-1:0] {
    OP_NONE   = 3'd0,
    OP_SELECT = 3'd1,
    OP_CANCEL = 3'd2,
    OP_LEFT   = 3'd3,
    OP_RIGHT  = 3'd4,
    OP_UP     = 3'd5,
    OP_DOWN   = 3'd6
  } op_t;

endpackage

// File: rtl/button_debouncer.sv
// One raw button: 2-flop synchroniser, debounce counter, stable level,
// press pulse and optional auto-repeat pulse train.
module button_debouncer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 15_000_000,
  parameter int CNT_W           = 27,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic event_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               REP_ON   = REPEAT_EN && (REPEAT_DELAY != 0);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic             stable_d_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic             rep_fire;
  logic             rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      stable_q   <= 1'b0;
      stable_d_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      sync_q     <= {sync_q[0], btn_raw};
      stable_d_q <= stable_q;
      if (sync_q[1] == stable_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        stable_q  <= ~stable_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  generate
    if (REP_ON) begin : g_repeat
      localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
      localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

      logic [CNT_W-1:0] rep_cnt_q;
      logic             rep_phase_q;
      logic             rep_fire_q;

      // rep_phase_q selects the period target once the first repeat has fired
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rep_cnt_q   <= '0;
          rep_phase_q <= 1'b0;
          rep_fire_q  <= 1'b0;
        end else if (!stable_q) begin
          rep_cnt_q   <= '0;
          rep_phase_q <= 1'b0;
          rep_fire_q  <= 1'b0;
        end else if (rep_cnt_q == (rep_phase_q ? PER_LAST : DLY_LAST)) begin
          rep_cnt_q   <= '0;
          rep_phase_q <= 1'b1;
          rep_fire_q  <= 1'b1;
        end else begin
          rep_cnt_q   <= rep_cnt_q + 1'b1;
          rep_fire_q  <= 1'b0;
        end
      end

      assign rep_fire = rep_fire_q;
    end else begin : g_no_repeat
      assign rep_fire = 1'b0;
    end
  endgenerate

  // Gating with stable_q drops a repeat that lands on the release edge
  assign rise        = stable_q & ~stable_d_q;
  assign event_pulse = rise | (rep_fire & stable_q);
  assign level       = stable_q;

endmodule

// File: rtl/button_op_encoder.sv
// Six debounced buttons feeding a fixed-priority encoder and a registered
// one-cycle operation code.
module button_op_encoder
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 15_000_000,
  parameter int CNT_W           = 27
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_select,
  input  logic            btn_cancel,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_up,
  input  logic            btn_down,
  output logic [OP_W-1:0] operation,
  output logic [5:0]      btn_held
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_event;
  logic [NUM_BTN-1:0] btn_level;
  op_t                op_next;

  assign btn_raw = {btn_down, btn_up, btn_right, btn_left, btn_cancel, btn_select};

  // Bits 2..5 are the shift buttons and get auto-repeat
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W),
      .REPEAT_EN       (i >= 2)
    ) u_deb (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[i]),
      .level       (btn_level[i]),
      .event_pulse (btn_event[i])
    );
  end

  always_comb begin
    op_next = OP_NONE;
    if      (btn_event[0]) op_next = OP_SELECT;
    else if (btn_event[1]) op_next = OP_CANCEL;
    else if (btn_event[2]) op_next = OP_LEFT;
    else if (btn_event[3]) op_next = OP_RIGHT;
    else if (btn_event[4]) op_next = OP_UP;
    else if (btn_event[5]) op_next = OP_DOWN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operation <= OP_NONE;
    end else begin
      operation <= op_next;
    end
  end

  assign btn_held = btn_level;

endmodule

// File: tb/tb_button_op_encoder.sv
// Scoreboard bench for button_op_encoder with short debounce/repeat timings.
module tb_button_op_encoder;

  localparam int DEB = 4;
  localparam int RD  = 16;
  localparam int RP  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_select = 1'b0, btn_cancel = 1'b0, btn_left = 1'b0;
  logic       btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [2:0] operation;
  logic [5:0] btn_held;

  typedef struct {
    int         cyc;
    logic [2:0] op;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  bit   mon_stop = 1'b0;

  button_op_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (27)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_select (btn_select),
    .btn_cancel (btn_cancel),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .operation  (operation),
    .btn_held   (btn_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // k: edge where raw high is first sampled; hold: cycles until raw low is first sampled.
  task automatic push_press(input int k, input int hold, input logic [2:0] op, input bit rep);
    int t0;
    int t;
    t0 = k + DEB + 2;
    sb.push_back('{t0, op});
    if (rep) begin
      for (int n = 0; n < 64; n++) begin
        t = t0 + RD + n * RP;
        if (t - 1 > k + hold + DEB) break;
        sb.push_back('{t, op});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    logic [2:0] e;
    while (!mon_stop) begin
      @(negedge clk);
      e = 3'd0;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb[0].op;
        void'(sb.pop_front());
      end
      chk_cnt++;
      if (operation !== e) $display("FAIL op_stream cyc=%0d got=%0d exp=%0d", cyc, operation, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    idle(3);
    chk_cnt++;
    if (operation !== 3'd0) $display("FAIL reset_op got=%0d exp=0", operation);
    else pass_cnt++;
    chk_cnt++;
    if (btn_held !== 6'd0) $display("FAIL reset_held got=%b exp=000000", btn_held);
    else pass_cnt++;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_clean_press();
    int k;
    k = cyc + 1;
    btn_left = 1'b1;
    push_press(k, 40, 3'd3, 1'b1);
    idle(20);
    chk_cnt++;
    if (btn_held !== 6'b000100) $display("FAIL clean_held got=%b exp=000100", btn_held);
    else pass_cnt++;
    idle(20);
    btn_left = 1'b0;
    idle(12);
    chk_cnt++;
    if (btn_held !== 6'd0) $display("FAIL clean_release got=%b exp=000000", btn_held);
    else pass_cnt++;
  endtask

  task automatic test_bouncy();
    int k;
    for (int i = 0; i < 6; i++) begin
      btn_up = ~btn_up;
      idle(2);
    end
    k = cyc + 1;
    btn_up = 1'b1;
    push_press(k, 14, 3'd5, 1'b1);
    idle(14);
    btn_up = 1'b0;
    idle(12);
  endtask

  task automatic test_repeat();
    int k;
    k = cyc + 1;
    btn_right = 1'b1;
    push_press(k, 60, 3'd4, 1'b1);
    idle(60);
    btn_right = 1'b0;
    idle(12);
    k = cyc + 1;
    btn_select = 1'b1;
    push_press(k, 60, 3'd1, 1'b0);
    idle(60);
    btn_select = 1'b0;
    idle(12);
  endtask

  task automatic test_simultaneous();
    int k;
    k = cyc + 1;
    btn_select = 1'b1;
    btn_down   = 1'b1;
    push_press(k, 10, 3'd1, 1'b0);
    idle(8);
    chk_cnt++;
    if (btn_held !== 6'b100001) $display("FAIL simul_held got=%b exp=100001", btn_held);
    else pass_cnt++;
    idle(2);
    btn_select = 1'b0;
    btn_down   = 1'b0;
    idle(12);
  endtask

  task automatic test_reset_mid_debounce();
    int k;
    btn_cancel = 1'b1;
    idle(2);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (operation !== 3'd0) $display("FAIL rst_mid_op got=%0d exp=0", operation);
    else pass_cnt++;
    chk_cnt++;
    if (btn_held !== 6'd0) $display("FAIL rst_mid_held got=%b exp=000000", btn_held);
    else pass_cnt++;
    idle(3);
    rst_n = 1'b1;
    k = cyc + 1;
    push_press(k, 20, 3'd2, 1'b0);
    idle(20);
    btn_cancel = 1'b0;
    idle(12);
  endtask

  task automatic test_short_release();
    int k;
    k = cyc + 1;
    btn_down = 1'b1;
    push_press(k, 15, 3'd6, 1'b1);
    idle(6);
    btn_down = 1'b0;
    idle(3);
    chk_cnt++;
    if (btn_held[5] !== 1'b1) $display("FAIL short_drop_held got=%b exp=1", btn_held[5]);
    else pass_cnt++;
    btn_down = 1'b1;
    idle(6);
    chk_cnt++;
    if (btn_held[5] !== 1'b1) $display("FAIL short_restore_held got=%b exp=1", btn_held[5]);
    else pass_cnt++;
    btn_down = 1'b0;
    idle(12);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_clean_press();
    test_bouncy();
    test_repeat();
    test_simultaneous();
    test_reset_mid_debounce();
    test_short_release();
    idle(5);
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drain got=%0d exp=0", sb.size());
    else pass_cnt++;
    mon_stop = 1'b1;
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
